// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, FSM state and shift-kind types shared by alu_secuencial and desplazador_iter
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_BNE  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;
  localparam logic [3:0] ALU_BEQ  = 4'b1111;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} estado_alu_t;
  typedef enum logic [1:0] {SH_L, SH_RL, SH_RA} shift_op_t;
  function automatic shift_op_t to_shift_op(input logic [3:0] op);
    return op == ALU_SLL ? SH_L : op == ALU_SRL ? SH_RL : SH_RA;
  endfunction
endpackage

// File: rtl/desplazador_iter.sv
// desplazador_iter: iterative 1-bit-per-cycle shifter
//   clk, rst_n      : clock, async active-low reset
//   load_i          : latch a_i, op_i, shamt_i
//   step_i          : shift one bit and decrement the counter
//   dato_sig_o      : value after the next step (registered by the caller on the final step)
//   fin_o           : the next step is the last one
module desplazador_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  shift_op_t        op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic [WIDTH-1:0] dato_sig_o,
  output logic             fin_o
);
  logic [WIDTH-1:0] dato_q;
  logic [SHW-1:0]   cnt_q;
  shift_op_t        op_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dato_q <= '0;
      cnt_q  <= '0;
      op_q   <= SH_L;
    end else if (load_i) begin
      dato_q <= a_i;
      cnt_q  <= shamt_i;
      op_q   <= op_i;
    end else if (step_i) begin
      dato_q <= dato_sig_o;
      cnt_q  <= cnt_q - SHW'(1);
    end
  // SRA refills from the current MSB, which stays equal to the latched A sign bit
  always_comb begin
    dato_sig_o = op_q == SH_L  ? {dato_q[WIDTH-2:0], 1'b0} :
                 op_q == SH_RL ? {1'b0, dato_q[WIDTH-1:1]} :
                                 {dato_q[WIDTH-1], dato_q[WIDTH-1:1]};
    fin_o      = cnt_q == SHW'(1);
  end
endmodule

// File: rtl/alu_secuencial.sv
// alu_secuencial: RV32I execution ALU with start/busy/done handshake; FAST_SHIFT_EN selects a barrel shifter
//   CLK, RST_n       : clock, async active-low reset
//   start            : launch op (accepted in IDLE or DONE)
//   ALU_control, A, B: op code and operands, sampled on the accepting edge
//   result, flag     : registered result and branch/zero flag, held until the next done
//   busy, done       : multi-cycle shift in progress / one-cycle result-valid pulse
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             busy,
  output logic             done
);
  estado_alu_t      state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, res_now, res_sh;
  logic             flag_q, flag_d, flag_now, accept, launch_shift, fin;
  logic [SHW-1:0]   shamt;
  assign shamt  = B[SHW-1:0];
  assign accept = start && state_q != SHIFT;
  always_comb begin
    case (ALU_control)
      ALU_SUB, ALU_BEQ, ALU_BNE: res_now = A - B;
      ALU_OR:   res_now = A | B;
      ALU_AND:  res_now = A & B;
      ALU_XOR:  res_now = A ^ B;
      ALU_SLT:  res_now = WIDTH'($signed(A) < $signed(B));
      ALU_SLTU: res_now = WIDTH'(A < B);
`ifdef FAST_SHIFT_EN
      ALU_SLL:  res_now = A << shamt;
      ALU_SRL:  res_now = A >> shamt;
      ALU_SRA:  res_now = $unsigned($signed(A) >>> shamt);
`else
      // only reached with shamt == 0; nonzero amounts go to the iterative unit
      ALU_SLL, ALU_SRL, ALU_SRA: res_now = A;
`endif
      default:  res_now = A + B;
    endcase
    flag_now = ALU_control == ALU_BEQ ? A == B :
               ALU_control == ALU_BNE ? A != B : res_now == '0;
  end
`ifdef FAST_SHIFT_EN
  assign launch_shift = 1'b0;
  assign fin          = 1'b0;
  assign res_sh       = '0;
`else
  assign launch_shift = accept && ALU_control inside {ALU_SLL, ALU_SRL, ALU_SRA} && shamt != '0;
  desplazador_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_desp (
    .clk       (CLK),
    .rst_n     (RST_n),
    .load_i    (launch_shift),
    .step_i    (state_q == SHIFT),
    .op_i      (to_shift_op(ALU_control)),
    .a_i       (A),
    .shamt_i   (shamt),
    .dato_sig_o(res_sh),
    .fin_o     (fin)
  );
`endif
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  always_comb begin
    state_d  = state_q == SHIFT ? (fin ? DONE : SHIFT) :
               launch_shift ? SHIFT : accept ? DONE : IDLE;
    result_d = result_q;
    flag_d   = flag_q;
    if (accept && !launch_shift) begin
      result_d = res_now;
      flag_d   = flag_now;
    end else if (state_q == SHIFT && fin) begin
      result_d = res_sh;
      flag_d   = res_sh == '0;
    end
  end
  always_comb begin
    busy   = state_q == SHIFT;
    done   = state_q == DONE;
    result = result_q;
    flag   = flag_q;
  end
endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: directed self-checking bench for alu_secuencial
module tb_alu_secuencial;
  logic        CLK = 1'b0, RST_n = 1'b0, start = 1'b0, flag, busy, done;
  logic [3:0]  ALU_control = 4'b0;
  logic [31:0] A = '0, B = '0, result;
  int          n_checks = 0, n_errors = 0;

  alu_secuencial dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .ALU_control(ALU_control),
    .A(A), .B(B), .result(result), .flag(flag), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int sh_lat(input int n);
`ifdef FAST_SHIFT_EN
    return 1;
`else
    return n == 0 ? 1 : n + 1;
`endif
  endfunction

  // called at the negedge after the accepting edge; returns at the negedge where done is seen
  task automatic wait_done(input bit poke, output int lat, output int nbusy);
    lat = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      nbusy += int'(busy);
      start = poke && busy;
      A = $urandom;
      B = $urandom;
      ALU_control = 4'($urandom);
      @(negedge CLK);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat_exp, input logic [31:0] res_exp, input logic flag_exp, input bit poke);
    int lat, nbusy;
    @(negedge CLK);
    start = 1'b1; ALU_control = op; A = a; B = b;
    @(negedge CLK);
    start = 1'b0;
    wait_done(poke, lat, nbusy);
    check({tag, "_lat"}, lat, lat_exp);
    check({tag, "_busy"}, nbusy, lat_exp - 1);
    check({tag, "_res"}, result, res_exp);
    check({tag, "_flag"}, 32'(flag), 32'(flag_exp));
  endtask

  initial begin
    int lat, nbusy;
    repeat (2) @(negedge CLK);
    check("rst_res", result, 32'h0);
    check("rst_flag", 32'(flag), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    RST_n = 1'b1;

    do_op("add",   4'b0000, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1'b1, 0);
    do_op("sub",   4'b0111, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1'b0, 0);
    do_op("slt",   4'b0100, 32'hFFFF_FFFF, 32'h1, 1, 32'h1, 1'b0, 0);
    do_op("sltu",  4'b1101, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1'b1, 0);
    do_op("beq",   4'b1111, 32'h1234, 32'h1234, 1, 32'h0, 1'b1, 0);
    do_op("bne",   4'b0011, 32'h1234, 32'h1234, 1, 32'h0, 1'b0, 0);
    do_op("bne_t", 4'b0011, 32'h1235, 32'h1234, 1, 32'h1, 1'b1, 0);
    do_op("or",    4'b0001, 32'hF0, 32'h0F, 1, 32'hFF, 1'b0, 0);
    do_op("and",   4'b0010, 32'hF0F0, 32'hFF00, 1, 32'hF000, 1'b0, 0);
    do_op("undef", 4'b0101, 32'd3, 32'd4, 1, 32'd7, 1'b0, 0);
    do_op("sra31", 4'b1110, 32'h8000_0000, 32'd31, sh_lat(31), 32'hFFFF_FFFF, 1'b0, 1);
    do_op("sll0",  4'b1000, 32'h1, 32'h20, 1, 32'h1, 1'b0, 0);
    do_op("sll4",  4'b1000, 32'h1, 32'h4, sh_lat(4), 32'h10, 1'b0, 1);
    do_op("srl4",  4'b1010, 32'hF000_0000, 32'hFFFF_FFE4, sh_lat(4), 32'h0F00_0000, 1'b0, 0);
    do_op("sra1",  4'b1110, 32'h4000_0000, 32'd1, sh_lat(1), 32'h2000_0000, 1'b0, 0);
    do_op("sll_z", 4'b1000, 32'h8000_0000, 32'd1, sh_lat(1), 32'h0, 1'b1, 0);

    // reset in the middle of a long SRL
    @(negedge CLK);
    start = 1'b1; ALU_control = 4'b1010; A = 32'hFFFF_0000; B = 32'd20;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
`ifndef FAST_SHIFT_EN
    check("mid_busy", 32'(busy), 1);
`endif
    RST_n = 1'b0;
    #1;
    check("abort_res", result, 32'h0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    @(negedge CLK);
    check("abort_done2", 32'(done), 0);
    RST_n = 1'b1;
    do_op("add_post", 4'b0000, 32'd10, 32'd20, 1, 32'd30, 1'b0, 0);

    // XOR accepted in the DONE cycle of an SRL
    @(negedge CLK);
    start = 1'b1; ALU_control = 4'b1010; A = 32'h8000_0000; B = 32'd3;
    @(negedge CLK);
    start = 1'b0;
    wait_done(0, lat, nbusy);
    check("b2b_srl_lat", lat, sh_lat(3));
    check("b2b_srl_res", result, 32'h1000_0000);
    start = 1'b1; ALU_control = 4'b1001; A = 32'hF0F0; B = 32'h0FF0;
    @(negedge CLK);
    start = 1'b0;
    check("b2b_xor_done", 32'(done), 1);
    check("b2b_xor_res", result, 32'hFF00);
    check("b2b_xor_flag", 32'(flag), 0);
    @(negedge CLK);
    check("b2b_idle", 32'(done), 0);
    check("b2b_hold", result, 32'hFF00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
